// File: rtl/acc_cpu_core_pkg.sv
// acc_cpu_core shared definitions: opcodes, FSM states and flag bit positions.
package acc_cpu_core_pkg;

    typedef enum logic [2:0] {
        OP_LDI = 3'd0,
        OP_LDR = 3'd1,
        OP_STR = 3'd2,
        OP_ADD = 3'd3,
        OP_SUB = 3'd4,
        OP_LW  = 3'd5,
        OP_SW  = 3'd6,
        OP_BRZ = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

endpackage

// File: rtl/acc_cpu_core_gp_regfile.sv
// General register file: async read, sync write, synchronous clear on reset.
module acc_cpu_core_gp_regfile #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU core with fetch/decode/exec/mem FSM
// and a req/ack memory port that tolerates wait states.
module acc_cpu_core
    import acc_cpu_core_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] acc_out,
    output logic [1:0]        flags_out
);

    localparam int IMM_W  = DATA_W - 3;
    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [DATA_W-1:0] acc, acc_nx;
    logic [DATA_W-1:0] ir, ir_nx;
    logic [DATA_W-1:0] opnd, opnd_nx;
    logic              zero, zero_nx;
    logic              carry, carry_nx;

    op_t               op;
    logic [IMM_W-1:0]  imm;
    logic [RIDX_W-1:0] ridx;
    logic [DATA_W-1:0] imm_sext;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] pc_instr;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;

    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;
    logic              req_int;
    logic              we_int;

    assign op       = op_t'(ir[DATA_W-1 -: 3]);
    assign imm      = ir[IMM_W-1:0];
    assign ridx     = imm[RIDX_W-1:0];
    assign imm_sext = {{3{imm[IMM_W-1]}}, imm};
    assign br_off   = imm_sext[ADDR_W-1:0];
    // pc already points past the branch when it executes
    assign pc_instr = pc - ADDR_W'(1);
    assign sum      = {1'b0, acc} + {1'b0, opnd};
    assign diff     = {1'b0, acc} - {1'b0, opnd};

    acc_cpu_core_gp_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (RIDX_W)
    ) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (rf_we),
        .waddr (ridx),
        .wdata (rf_wdata),
        .raddr (ridx),
        .rdata (rf_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
            pc    <= ADDR_W'(RESET_PC);
            acc   <= '0;
            ir    <= '0;
            opnd  <= '0;
            zero  <= 1'b0;
            carry <= 1'b0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            acc   <= acc_nx;
            ir    <= ir_nx;
            opnd  <= opnd_nx;
            zero  <= zero_nx;
            carry <= carry_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        acc_nx    = acc;
        ir_nx     = ir;
        opnd_nx   = opnd;
        zero_nx   = zero;
        carry_nx  = carry;
        rf_we     = 1'b0;
        rf_wdata  = acc;
        req_int   = 1'b0;
        we_int    = 1'b0;
        mem_addr  = pc;
        mem_wdata = opnd;

        unique case (state)
            ST_FETCH: begin
                req_int = 1'b1;
                if (mem_ack) begin
                    ir_nx    = mem_rdata;
                    pc_nx    = pc + ADDR_W'(1);
                    state_nx = ST_DECODE;
                end
            end
            ST_DECODE: begin
                opnd_nx  = rf_rdata;
                state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                state_nx = ST_FETCH;
                unique case (op)
                    OP_LDI: begin
                        acc_nx  = imm_sext;
                        zero_nx = (imm_sext == '0);
                    end
                    OP_LDR: begin
                        acc_nx  = opnd;
                        zero_nx = (opnd == '0);
                    end
                    OP_STR: rf_we = 1'b1;
                    OP_ADD: begin
                        {carry_nx, acc_nx} = sum;
                        zero_nx = (sum[DATA_W-1:0] == '0);
                    end
                    OP_SUB: begin
                        {carry_nx, acc_nx} = diff;
                        zero_nx = (diff[DATA_W-1:0] == '0);
                    end
                    OP_LW, OP_SW: state_nx = ST_MEM;
                    OP_BRZ: begin
                        if (imm == '0) begin
                            state_nx = ST_HALT;
                        end else if (zero) begin
                            pc_nx = pc_instr + br_off;
                        end
                    end
                endcase
            end
            ST_MEM: begin
                req_int  = 1'b1;
                we_int   = (op == OP_SW);
                mem_addr = acc[ADDR_W-1:0];
                if (mem_ack) begin
                    state_nx = ST_FETCH;
                    if (op == OP_LW) begin
                        rf_we    = 1'b1;
                        rf_wdata = mem_rdata;
                    end
                end
            end
            ST_HALT: begin
                state_nx = ST_HALT;
            end
            default: begin
                state_nx = ST_FETCH;
            end
        endcase
    end

    // a pending transfer is dropped the moment reset rises
    assign mem_req = req_int & ~reset;
    assign mem_we  = we_int & ~reset;

    assign halted            = (state == ST_HALT);
    assign pc_out            = pc;
    assign acc_out           = acc;
    assign flags_out[FLAG_Z] = zero;
    assign flags_out[FLAG_C] = carry;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: wait-state memory model with read/write scoreboards
// plus a 16-bit build exercised from a separate zero-wait memory.
module tb_acc_cpu_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       mem_req, mem_we, mem_ack, halted;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, pc_out, acc_out;
    logic [1:0] flags_out;

    logic        reset16, req16, we16, halted16;
    logic [7:0]  addr16, pc16;
    logic [15:0] wdata16, rdata16, acc16;
    logic [1:0]  flags16;

    int checks = 0;
    int failures = 0;
    int wait_n = 0;
    int wcnt = 0;
    int gen = 1;

    logic [7:0]  mem  [256];
    logic [7:0]  wmem [256];
    int          wtag [256];
    logic [15:0] mem16 [256];
    logic [7:0]  exp_rd [$];
    logic [15:0] exp_wr [$];

    logic       hold_v = 1'b0;
    logic       hold_we;
    logic [7:0] hold_addr, hold_wdata;

    acc_cpu_core dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .halted    (halted),
        .pc_out    (pc_out),
        .acc_out   (acc_out),
        .flags_out (flags_out)
    );

    acc_cpu_core #(
        .DATA_W   (16),
        .ADDR_W   (8),
        .NUM_REGS (16),
        .RESET_PC (0)
    ) dut16 (
        .clk       (clk),
        .reset     (reset16),
        .mem_req   (req16),
        .mem_we    (we16),
        .mem_addr  (addr16),
        .mem_wdata (wdata16),
        .mem_rdata (rdata16),
        .mem_ack   (req16),
        .halted    (halted16),
        .pc_out    (pc16),
        .acc_out   (acc16),
        .flags_out (flags16)
    );

    assign rdata16   = mem16[addr16];
    assign mem_ack   = mem_req && (wcnt == wait_n);
    assign mem_rdata = (wtag[mem_addr] == gen) ? wmem[mem_addr] : mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // memory responder + scoreboards
    always @(posedge clk) begin
        logic [7:0]  er;
        logic [15:0] ew;
        if (hold_v && !reset) begin
            check("hold_req", mem_req, 1);
            check("hold_addr", mem_addr, hold_addr);
            check("hold_we", mem_we, hold_we);
            if (hold_we) check("hold_wdata", mem_wdata, hold_wdata);
        end
        hold_v     <= mem_req && !mem_ack;
        hold_addr  <= mem_addr;
        hold_we    <= mem_we;
        hold_wdata <= mem_wdata;
        if (mem_req && mem_ack) begin
            wcnt <= 0;
            if (mem_we) begin
                ew = (exp_wr.size() != 0) ? exp_wr.pop_front() : 16'hxxxx;
                check("mem_write", {mem_addr, mem_wdata}, ew);
                wmem[mem_addr] <= mem_wdata;
                wtag[mem_addr] <= gen;
            end else begin
                er = (exp_rd.size() != 0) ? exp_rd.pop_front() : 8'hxx;
                check("mem_read", mem_addr, er);
            end
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    task automatic new_prog();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        gen++;
        exp_rd.delete();
        exp_wr.delete();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic put(input int a, input logic [7:0] v);
        mem[a] = v;
    endtask

    task automatic rd(input logic [7:0] a);
        exp_rd.push_back(a);
    endtask

    task automatic rd_seq(input int first, input int n);
        for (int i = 0; i < n; i++) exp_rd.push_back(8'(first + i));
    endtask

    task automatic go(input int wn);
        wait_n = wn;
        @(posedge clk);
        #1;
        check("rst_pc", pc_out, 8'h00);
        check("rst_acc", acc_out, 8'h00);
        check("rst_flags", flags_out, 2'b00);
        check("rst_halted", halted, 1'b0);
        check("rst_req", mem_req, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_halt(input string tag, input int exp_cyc,
                            input logic [7:0] exp_acc, input logic [1:0] exp_fl,
                            input logic [7:0] exp_pc);
        int cyc = 0;
        while (!halted && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_acc"}, acc_out, exp_acc);
        check({tag, "_flags"}, flags_out, exp_fl);
        check({tag, "_pc"}, pc_out, exp_pc);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_halted"}, halted, 1'b1);
        check({tag, "_halt_req"}, mem_req, 1'b0);
        check({tag, "_rd_left"}, exp_rd.size(), 0);
        check({tag, "_wr_left"}, exp_wr.size(), 0);
    endtask

    initial begin
        int cyc;
        reset   = 1'b1;
        reset16 = 1'b1;
        for (int i = 0; i < 256; i++) mem16[i] = 16'h0000;
        mem16[0] = 16'h1FFB;
        mem16[1] = 16'h401F;
        mem16[2] = 16'h0000;
        mem16[3] = 16'h200F;
        mem16[4] = 16'hE000;

        // LDI 5; STR r1; LDI 3; ADD r1; HALT
        new_prog();
        put(0, 8'h05); put(1, 8'h41); put(2, 8'h03);
        put(3, 8'h61); put(4, 8'hE0);
        rd_seq(0, 5);
        go(0);
        run_halt("add", 15, 8'h08, 2'b00, 8'h05);

        // taken branch skips LDI 7
        new_prog();
        put(0, 8'h00); put(1, 8'hE2); put(2, 8'h07);
        put(3, 8'h01); put(4, 8'hE0);
        rd(0); rd(1); rd(3); rd(4);
        go(0);
        run_halt("brz_t", 12, 8'h01, 2'b00, 8'h05);

        // not taken: LDI 7 fetched and executed
        new_prog();
        put(0, 8'h04); put(1, 8'hE2); put(2, 8'h07);
        put(3, 8'h01); put(4, 8'hE0);
        rd_seq(0, 5);
        go(0);
        run_halt("brz_nt", 15, 8'h01, 2'b00, 8'h05);

        // 0xFF + 1 -> 0, carry and zero set
        new_prog();
        put(0, 8'h01); put(1, 8'h40); put(2, 8'h1F);
        put(3, 8'h60); put(4, 8'hE0);
        rd_seq(0, 5);
        go(0);
        run_halt("ovf", 15, 8'h00, 2'b11, 8'h05);

        // then 0 - 1 -> 0xFF with borrow
        new_prog();
        put(0, 8'h01); put(1, 8'h40); put(2, 8'h1F);
        put(3, 8'h60); put(4, 8'h80); put(5, 8'hE0);
        rd_seq(0, 6);
        go(0);
        run_halt("borrow", 18, 8'hFF, 2'b10, 8'h06);

        // memory ops, 2 wait states per transfer
        new_prog();
        put(0, 8'h1E); put(1, 8'hA2); put(2, 8'h08);
        put(3, 8'h44); put(4, 8'h64); put(5, 8'hC2);
        put(6, 8'hA3); put(7, 8'h23); put(8, 8'hE0);
        put(8'hFE, 8'h5A);
        rd(0); rd(1); rd(8'hFE); rd(2); rd(3); rd(4); rd(5);
        rd(6); rd(8'h10); rd(7); rd(8);
        exp_wr.push_back({8'h10, 8'h5A});
        go(2);
        run_halt("memws", 54, 8'h5A, 2'b00, 8'h09);

        // reset while a fetch is waiting for ack
        new_prog();
        put(0, 8'h05); put(1, 8'h41); put(2, 8'h03);
        put(3, 8'h61); put(4, 8'hE0);
        rd(0);
        go(5);
        repeat (9) @(posedge clk);
        #1;
        check("mid_acc", acc_out, 8'h05);
        check("mid_pc", pc_out, 8'h01);
        check("mid_req", mem_req, 1'b1);
        check("mid_addr", mem_addr, 8'h01);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_req", mem_req, 1'b0);
        check("mid_rd_left", exp_rd.size(), 0);
        rd_seq(0, 5);
        go(0);
        run_halt("restart", 15, 8'h08, 2'b00, 8'h05);

        // backward branch to 0xFE, then pc wraps 0xFF -> 0x00
        new_prog();
        put(0, 8'h27); put(1, 8'hFD); put(2, 8'hE0);
        put(8'hFE, 8'h01); put(8'hFF, 8'h47);
        rd(0); rd(1); rd(8'hFE); rd(8'hFF); rd(0); rd(1); rd(2);
        go(0);
        run_halt("wrap", 21, 8'h01, 2'b00, 8'h03);

        // 16-bit build: sign extension and register 15
        @(posedge clk);
        #1;
        check("w16_rst_acc", acc16, 16'h0000);
        check("w16_rst_req", req16, 1'b0);
        @(negedge clk);
        reset16 = 1'b0;
        cyc = 0;
        while (!halted16 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("w16_cycles", cyc, 15);
        check("w16_acc", acc16, 16'hFFFB);
        check("w16_flags", flags16, 2'b00);
        check("w16_pc", pc16, 8'h05);
        check("w16_we", we16, 1'b0);
        check("w16_wdata_def", wdata16 === 16'hxxxx, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
